spi_dma_fifo: RTL and testbench
===============================

# spi_dma_fifo

Dual-direction buffering stage between the SPI shifter and the SPI DMA engine inside the SPI core. It holds up to DEPTH received frames until the DMA drains them, and up to DEPTH frames to be transmitted until the shifter consumes them. This decouples single-frame SPI timing from AXI burst latency. It raises DMA request levels by fill threshold and flags overrun and underrun conditions to the interrupt line.

## Interface
- DEPTH, 8: entries per direction; power of two, ≥2.
- DW, 16: frame width in bits.
- RX_THRES, 1: RX fill level (1..DEPTH) at or above which dma_rxreq is asserted.
- TX_THRES, 1: TX free-slot level (1..DEPTH) at or above which dma_txreq is asserted.

Ports:
- clk  in  1  single clock; every register is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of both FIFOs; sticky flags are preserved.
- spi_rx_vld  in  1  one-cycle pulse: the shifter has completed a received frame.
- spi_rx_data  in  DW  received frame; valid when spi_rx_vld=1.
- dma_rxpop  in  1  DMA consumes the RX head entry.
- dma_rxbuff  out  DW  RX head entry (first-word fall-through); 0 when RX is empty.
- dma_rxne  out  1  RX count ≠ 0.
- dma_rxreq  out  1  RX count ≥ RX_THRES.
- dma_txpush  in  1  DMA writes dma_txdata into TX.
- dma_txdata  in  DW  TX write data.
- dma_txreq  out  1  (DEPTH − TX count) ≥ TX_THRES.
- spi_txe  out  1  TX count = 0.
- spi_tx_pop  in  1  shifter takes the TX head entry at frame start.
- spi_tx_data  out  DW  TX head entry; 0 when TX is empty.
- ovr_clr  in  1  clears all sticky flags.
- rx_ovr  out  1  sticky: an RX frame arrived while RX was full.
- tx_ovf  out  1  sticky: dma_txpush occurred while TX was full.
- tx_udr  out  1  sticky: spi_tx_pop occurred while TX was empty.
- irq_out  out  1  registered OR of rx_ovr, tx_ovf and tx_udr.

## Operation
- Each direction is a circular buffer with read and write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH with no special case.
- Write accepted: write the entry, then write pointer +1 and count +1.
- Read accepted: read pointer +1 and count −1.
- Simultaneous push and pop:
  - Non-empty and not full: both are accepted; count is unchanged.
  - Full: both are accepted; count stays DEPTH; no overflow flag is set.
  - Empty: only the push is accepted; the pop is ignored and tx_udr is set (TX side). There is no bypass path.
- Push while full (without a pop): data is dropped; pointers and count are unchanged. rx_ovr is set for RX; tx_ovf is set for TX.
- Pop while empty: ignored. On TX this sets tx_udr, and the shifter sends 0. On RX it is silently ignored.
- flush clears pointers and counts of both directions. It overrides any push or pop in the same cycle, and that push or pop does not set a flag.
- ovr_clr clears flags at the next edge. If a flag-setting event occurs in the same cycle, set wins.
- Status outputs (dma_rxne, dma_rxreq, dma_txreq, spi_txe) are decoded combinationally from the count registers only. Data outputs are a mux of the memory at the read pointer, gated to 0 when the count is 0.

## Timing
- Reset (rst=1 at an edge): pointers, counts, flags and irq_out = 0. As a result: dma_rxne=0, dma_rxreq=0, dma_txreq=1, spi_txe=1, dma_rxbuff=0, spi_tx_data=0.
- Memory contents are not reset.
- Reset mid-operation discards all buffered data at that edge.
- Push at edge N: the entry and updated status are visible from N+1. dma_rxbuff shows a new head one cycle after the push into an empty FIFO.
- Pop at edge N: the next head is visible from N+1.
- Sticky flags assert one cycle after the offending edge. irq_out follows one cycle after that.
- Throughput: one push and one pop per direction per cycle, sustained.

## Test plan
- Reset then RX push sequence: pulse spi_rx_vld with 0x1111, 0x2222, 0x3333 on consecutive cycles, no pop → dma_rxne=1 after the first edge, dma_rxbuff=0x1111, count=3. Three dma_rxpop pulses then read 0x1111, 0x2222, 0x3333, after which dma_rxne=0 and dma_rxbuff=0.
- RX overrun: 9 pushes with DEPTH=8 → the 9th frame is dropped, rx_ovr=1 at N+1, irq_out=1 at N+2. ovr_clr → both return to 0. Popping 8 entries yields the first 8 values.
- Full boundary with simultaneous push and pop: RX full plus push 0xAAAA and pop together → no rx_ovr, count stays 8, and 0xAAAA is read last.
- TX thresholds with TX_THRES=4 and DEPTH=8: push 5 words → dma_txreq=0. One spi_tx_pop → dma_txreq=1. Drain to empty → spi_txe=1. One more pop → tx_udr=1 and spi_tx_data=0.
- Wrap-around: 20 push/pop cycles at count 3 → data order is preserved across pointer wrap.
- Flush and reset mid-stream: flush asserted together with a push at count 5 → both counts become 0, no flag is set, and rx_ovr stays at its previous value. A rst pulse then clears all flags.

Source files
------------

// File: rtl/spi_dma_fifo.sv
// spi_dma_fifo
// ------------
// Buffering stage between the SPI shifter and the SPI DMA engine.
// Holds up to DEPTH received frames (RX, shifter -> DMA) and up to DEPTH
// frames to transmit (TX, DMA -> shifter). DMA request levels are raised
// by fill threshold. Overrun, overflow and underrun events are kept in
// sticky flags, which drive a registered interrupt.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               clears both FIFOs; sticky flags are kept
//   spi_rx_vld/_data    received frame from the shifter (push into RX)
//   dma_rxpop           DMA consumes the RX head
//   dma_rxbuff          RX head (first-word fall-through), 0 when empty
//   dma_rxne/dma_rxreq  RX not-empty / RX fill >= RX_THRES
//   dma_txpush/_txdata  DMA writes a frame into TX
//   dma_txreq           TX free slots >= TX_THRES
//   spi_txe             TX empty
//   spi_tx_pop          shifter takes the TX head at frame start
//   spi_tx_data         TX head, 0 when empty
//   ovr_clr             clears all sticky flags
//   rx_ovr/tx_ovf/tx_udr sticky error flags
//   irq_out             registered OR of the sticky flags

// One direction of the stage: circular buffer with a fill count.
// Push while full is accepted only together with a pop; pop while empty is
// ignored. flush overrides both.
module spi_dma_fifo_buf #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_CNT = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW:0]   count_r;
  logic          empty_s;
  logic          full_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Accept decode: a full buffer still takes a push when a pop frees the slot
  // in the same cycle; an empty buffer never pops (no bypass path).
  always_comb begin
    empty_s   = (count_r == ZERO_CNT);
    full_s    = (count_r == FULL_CNT);
    pop_ok_s  = pop & ~flush & ~empty_s;
    push_ok_s = push & ~flush & (~full_s | pop);
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_r  <= PTR_ZERO;
      rptr_r  <= PTR_ZERO;
      count_r <= ZERO_CNT;
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wptr_r] <= push_data;
    end
  end

  // Head output, forced to 0 when empty so stale memory never leaks out.
  always_comb begin
    if (empty_s) begin
      head = {DW{1'b0}};
    end else begin
      head = mem_r[rptr_r];
    end
  end

  assign count = count_r;
endmodule

module spi_dma_fifo #(
  parameter int DEPTH    = 8,
  parameter int DW       = 16,
  parameter int RX_THRES = 1,
  parameter int TX_THRES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          spi_rx_vld,
  input  logic [DW-1:0] spi_rx_data,
  input  logic          dma_rxpop,
  output logic [DW-1:0] dma_rxbuff,
  output logic          dma_rxne,
  output logic          dma_rxreq,
  input  logic          dma_txpush,
  input  logic [DW-1:0] dma_txdata,
  output logic          dma_txreq,
  output logic          spi_txe,
  input  logic          spi_tx_pop,
  output logic [DW-1:0] spi_tx_data,
  input  logic          ovr_clr,
  output logic          rx_ovr,
  output logic          tx_ovf,
  output logic          tx_udr,
  output logic          irq_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT  = (AW+1)'(0);
  localparam logic [AW:0] RX_THR_CNT = (AW+1)'(RX_THRES);
  localparam logic [AW:0] TX_THR_CNT = (AW+1)'(TX_THRES);

  logic [AW:0] rx_count_s;
  logic [AW:0] tx_count_s;
  logic        rx_ovr_set_s;
  logic        tx_ovf_set_s;
  logic        tx_udr_set_s;
  logic        rx_ovr_r;
  logic        tx_ovf_r;
  logic        tx_udr_r;
  logic        irq_r;

  spi_dma_fifo_buf #(.DEPTH(DEPTH), .DW(DW)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (spi_rx_vld),
    .push_data (spi_rx_data),
    .pop       (dma_rxpop),
    .head      (dma_rxbuff),
    .count     (rx_count_s)
  );

  spi_dma_fifo_buf #(.DEPTH(DEPTH), .DW(DW)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (dma_txpush),
    .push_data (dma_txdata),
    .pop       (spi_tx_pop),
    .head      (spi_tx_data),
    .count     (tx_count_s)
  );

  // Status decode from the count registers, plus error-event detection.
  // A push into a full buffer is only an error when no pop accompanies it;
  // events during flush are suppressed.
  always_comb begin
    dma_rxne     = (rx_count_s != ZERO_CNT);
    dma_rxreq    = (rx_count_s >= RX_THR_CNT);
    dma_txreq    = ((FULL_CNT - tx_count_s) >= TX_THR_CNT);
    spi_txe      = (tx_count_s == ZERO_CNT);
    rx_ovr_set_s = spi_rx_vld & ~flush & (rx_count_s == FULL_CNT) & ~dma_rxpop;
    tx_ovf_set_s = dma_txpush & ~flush & (tx_count_s == FULL_CNT) & ~spi_tx_pop;
    tx_udr_set_s = spi_tx_pop & ~flush & (tx_count_s == ZERO_CNT);
  end

  // Sticky flags (set beats clear) and the interrupt, which lags the flags by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovr_r <= 1'b0;
      tx_ovf_r <= 1'b0;
      tx_udr_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      rx_ovr_r <= rx_ovr_set_s | (rx_ovr_r & ~ovr_clr);
      tx_ovf_r <= tx_ovf_set_s | (tx_ovf_r & ~ovr_clr);
      tx_udr_r <= tx_udr_set_s | (tx_udr_r & ~ovr_clr);
      irq_r    <= rx_ovr_r | tx_ovf_r | tx_udr_r;
    end
  end

  assign rx_ovr  = rx_ovr_r;
  assign tx_ovf  = tx_ovf_r;
  assign tx_udr  = tx_udr_r;
  assign irq_out = irq_r;
endmodule

// File: tb/tb_spi_dma_fifo.sv
// Self-checking bench for spi_dma_fifo (DEPTH=8, DW=16, RX_THRES=3, TX_THRES=4).
// A queue-based reference model tracks both directions and the flags.
module tb_spi_dma_fifo;
  localparam int DEPTH    = 8;
  localparam int DW       = 16;
  localparam int RX_THRES = 3;
  localparam int TX_THRES = 4;

  logic          clk = 1'b0;
  logic          rst, flush, spi_rx_vld, dma_rxpop, dma_txpush, spi_tx_pop, ovr_clr;
  logic [DW-1:0] spi_rx_data, dma_txdata;
  logic [DW-1:0] dma_rxbuff, spi_tx_data;
  logic          dma_rxne, dma_rxreq, dma_txreq, spi_txe;
  logic          rx_ovr, tx_ovf, tx_udr, irq_out;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] rxq[$];
  logic [DW-1:0] txq[$];
  logic m_ovr = 1'b0, m_ovf = 1'b0, m_udr = 1'b0, m_irq = 1'b0;

  spi_dma_fifo #(.DEPTH(DEPTH), .DW(DW), .RX_THRES(RX_THRES), .TX_THRES(TX_THRES)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .spi_rx_vld(spi_rx_vld), .spi_rx_data(spi_rx_data), .dma_rxpop(dma_rxpop),
    .dma_rxbuff(dma_rxbuff), .dma_rxne(dma_rxne), .dma_rxreq(dma_rxreq),
    .dma_txpush(dma_txpush), .dma_txdata(dma_txdata), .dma_txreq(dma_txreq),
    .spi_txe(spi_txe), .spi_tx_pop(spi_tx_pop), .spi_tx_data(spi_tx_data),
    .ovr_clr(ovr_clr), .rx_ovr(rx_ovr), .tx_ovf(tx_ovf), .tx_udr(tx_udr),
    .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: one clock edge with the currently driven inputs.
  task automatic model_apply();
    bit set_ovr, set_ovf, set_udr, irq_next;
    int n;
    if (rst) begin
      rxq.delete(); txq.delete();
      m_ovr = 1'b0; m_ovf = 1'b0; m_udr = 1'b0; m_irq = 1'b0;
      return;
    end
    irq_next = m_ovr | m_ovf | m_udr;
    set_ovr = 1'b0; set_ovf = 1'b0; set_udr = 1'b0;
    if (flush) begin
      rxq.delete(); txq.delete();
    end else begin
      n = rxq.size();
      if (dma_rxpop && n > 0) void'(rxq.pop_front());
      if (spi_rx_vld && (n < DEPTH || dma_rxpop)) rxq.push_back(spi_rx_data);
      set_ovr = spi_rx_vld && n == DEPTH && !dma_rxpop;
      n = txq.size();
      if (spi_tx_pop && n > 0) void'(txq.pop_front());
      if (dma_txpush && (n < DEPTH || spi_tx_pop)) txq.push_back(dma_txdata);
      set_ovf = dma_txpush && n == DEPTH && !spi_tx_pop;
      set_udr = spi_tx_pop && n == 0;
    end
    m_ovr = set_ovr | (m_ovr & !ovr_clr);
    m_ovf = set_ovf | (m_ovf & !ovr_clr);
    m_udr = set_udr | (m_udr & !ovr_clr);
    m_irq = irq_next;
  endtask

  task automatic check_model();
    logic [DW-1:0] erx, etx;
    erx = (rxq.size() > 0) ? rxq[0] : 16'h0000;
    etx = (txq.size() > 0) ? txq[0] : 16'h0000;
    chk("dma_rxbuff",  {16'h0000, dma_rxbuff},  {16'h0000, erx});
    chk("spi_tx_data", {16'h0000, spi_tx_data}, {16'h0000, etx});
    chk("dma_rxne",  {31'd0, dma_rxne},  {31'd0, rxq.size() != 0});
    chk("dma_rxreq", {31'd0, dma_rxreq}, {31'd0, rxq.size() >= RX_THRES});
    chk("dma_txreq", {31'd0, dma_txreq}, {31'd0, (DEPTH - txq.size()) >= TX_THRES});
    chk("spi_txe",   {31'd0, spi_txe},   {31'd0, txq.size() == 0});
    chk("rx_ovr",  {31'd0, rx_ovr},  {31'd0, m_ovr});
    chk("tx_ovf",  {31'd0, tx_ovf},  {31'd0, m_ovf});
    chk("tx_udr",  {31'd0, tx_udr},  {31'd0, m_udr});
    chk("irq_out", {31'd0, irq_out}, {31'd0, m_irq});
  endtask

  // Drive one cycle of inputs, advance past the edge, compare with the model.
  task automatic cyc(input logic r, input logic fl, input logic rv, input logic [DW-1:0] rd,
                     input logic rp, input logic tp, input logic [DW-1:0] td,
                     input logic tpop, input logic clr);
    rst = r; flush = fl; spi_rx_vld = rv; spi_rx_data = rd; dma_rxpop = rp;
    dma_txpush = tp; dma_txdata = td; spi_tx_pop = tpop; ovr_clr = clr;
    model_apply();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; spi_rx_vld = 1'b0; spi_rx_data = 16'h0000; dma_rxpop = 1'b0;
    dma_txpush = 1'b0; dma_txdata = 16'h0000; spi_tx_pop = 1'b0; ovr_clr = 1'b0;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("reset_txreq", {31'd0, dma_txreq}, 32'd1);
    chk("reset_txe",   {31'd0, spi_txe},   32'd1);
    chk("reset_rxbuff", {16'h0000, dma_rxbuff}, 32'h0);

    // RX push sequence, then pops in order
    cyc(1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("rxne_first", {31'd0, dma_rxne}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("rx_head_1111", {16'h0000, dma_rxbuff}, 32'h1111);
    chk("rxreq_at3", {31'd0, dma_rxreq}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("rx_head_2222", {16'h0000, dma_rxbuff}, 32'h2222);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("rx_head_3333", {16'h0000, dma_rxbuff}, 32'h3333);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("rx_empty_ne",  {31'd0, dma_rxne}, 32'd0);
    chk("rx_empty_buf", {16'h0000, dma_rxbuff}, 32'h0);

    // RX overrun: nine pushes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++)
      cyc(1'b0, 1'b0, 1'b1, 16'(i), 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("ovr_set", {31'd0, rx_ovr}, 32'd1);
    chk("ovr_irq_lag", {31'd0, irq_out}, 32'd0);
    idle();
    chk("ovr_irq", {31'd0, irq_out}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("ovr_clr", {31'd0, rx_ovr}, 32'd0);
    idle();
    chk("irq_clr", {31'd0, irq_out}, 32'd0);

    // Full boundary: push and pop together while full
    cyc(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("full_pp_no_ovr", {31'd0, rx_ovr}, 32'd0);
    chk("full_pp_head",   {16'h0000, dma_rxbuff}, 32'h0002);
    for (int i = 0; i < 7; i++)
      cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("full_pp_last", {16'h0000, dma_rxbuff}, 32'hAAAA);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

    // TX thresholds, drain and underrun
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'(16'hB000 + i), 1'b0, 1'b0);
    chk("txreq_5", {31'd0, dma_txreq}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("txreq_4", {31'd0, dma_txreq}, 32'd1);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("txe_drained", {31'd0, spi_txe}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("udr_set",  {31'd0, tx_udr}, 32'd1);
    chk("udr_data", {16'h0000, spi_tx_data}, 32'h0);

    // Wrap-around: steady push+pop at count 3 in both directions
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b1, 1'b1, 16'($urandom), 1'b1, 1'b0);

    // Flush mid-stream with rx_ovr already set
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("pre_flush_ovr", {31'd0, rx_ovr}, 32'd1);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b1, 16'h6666, 1'b0, 1'b0);
    chk("flush_rxne", {31'd0, dma_rxne}, 32'd0);
    chk("flush_txe",  {31'd0, spi_txe},  32'd1);
    chk("flush_ovr_kept", {31'd0, rx_ovr}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("rst_ovr", {31'd0, rx_ovr}, 32'd0);
    chk("rst_udr", {31'd0, tx_udr}, 32'd0);
    chk("rst_irq", {31'd0, irq_out}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
